// File: rtl/ccr_unit_pkg.sv
// Shared definitions for the condition-code register stage: flag bit indices,
// branch codes and small helpers used by ccr_unit and ccr_stack.
package ccr_unit_pkg;

  localparam int unsigned CCR_W = 4;

  // Bit positions of the flags inside the CCR word
  localparam int unsigned CCR_Z = 0;
  localparam int unsigned CCR_N = 1;
  localparam int unsigned CCR_C = 2;
  localparam int unsigned CCR_V = 3;

  typedef logic [CCR_W-1:0] ccr_t;

  // Branch codes; 5..7 are reserved and never taken
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_JZ   = 3'd1,
    BR_JN   = 3'd2,
    BR_JC   = 3'd3,
    BR_JMP  = 3'd4
  } brType_e;

  // Assemble the ALU's individual flag wires into CCR bit order
  function automatic ccr_t packAluFlags(input logic z, input logic n,
                                        input logic c, input logic v);
    ccr_t f;
    f        = '0;
    f[CCR_Z] = z;
    f[CCR_N] = n;
    f[CCR_C] = c;
    f[CCR_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/ccr_stack.sv
// Shadow LIFO of CCR snapshots for interrupt entry / RTI, with sticky
// overflow and underflow indicators.
module ccr_stack
  import ccr_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  ccr_t             pushData,
  output ccr_t             topData_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  ccr_t mem [DEPTH];

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);

  // Top of stack is the entry just below the fill pointer
  always_comb begin
    topData_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i + 1) == count) begin
        topData_c = mem[i];
      end
    end
  end

  // Pop beats push; blocked operations only raise the sticky error bits
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (pop) begin
      if (empty_c) begin
        underflow <= 1'b1;
      end else begin
        count <= count - CNT_W'(1);
      end
    end else if (push) begin
      if (full_c) begin
        overflow <= 1'b1;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == count) begin
            mem[i] <= pushData;
          end
        end
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register stage behind the ALU: masked flag capture, SETC/CLRC,
// branch evaluation with flag clear on taken branches, and shadow save/restore.
module ccr_unit
  import ccr_unit_pkg::*;
#(
  parameter  int unsigned STACK_DEPTH = 2,
  localparam int unsigned CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [3:0]       flagUpdateEn,
  input  logic             aluZero,
  input  logic             aluNegative,
  input  logic             aluCarry,
  input  logic             aluOverflow,
  input  logic             setCarry,
  input  logic             clrCarry,
  input  logic [2:0]       branchType,
  input  logic             saveFlags,
  input  logic             restoreFlags,
  output logic [3:0]       ccr,
  output logic             branchTaken,
  output logic             stackOverflow,
  output logic             stackUnderflow,
  output logic [CNT_W-1:0] stackCount
);

  ccr_t       aluFlags;
  ccr_t       nextCcr;
  ccr_t       stackTop;
  logic       condTaken;
  logic [1:0] testedIdx;
  logic       pushReq;
  logic       popReq;
  logic       stackFull;
  logic       stackEmpty;

  assign aluFlags = packAluFlags(aluZero, aluNegative, aluCarry, aluOverflow);

  // Branch decode straight off the registered flags; a stall suppresses it
  always_comb begin
    branchTaken = 1'b0;
    condTaken   = 1'b0;
    testedIdx   = 2'(CCR_Z);
    if (!stall) begin
      case (branchType)
        BR_JZ: begin
          testedIdx   = 2'(CCR_Z);
          branchTaken = ccr[CCR_Z];
          condTaken   = ccr[CCR_Z];
        end
        BR_JN: begin
          testedIdx   = 2'(CCR_N);
          branchTaken = ccr[CCR_N];
          condTaken   = ccr[CCR_N];
        end
        BR_JC: begin
          testedIdx   = 2'(CCR_C);
          branchTaken = ccr[CCR_C];
          condTaken   = ccr[CCR_C];
        end
        BR_JMP: begin
          branchTaken = 1'b1;
        end
        default: begin
          branchTaken = 1'b0;
        end
      endcase
    end
  end

  // Later assignments carry higher priority: clear, ALU value, CLRC, SETC
  always_comb begin
    nextCcr = ccr;
    if (condTaken) begin
      nextCcr[testedIdx] = 1'b0;
    end
    for (int unsigned i = 0; i < CCR_W; i++) begin
      if (flagUpdateEn[i]) begin
        nextCcr[i] = aluFlags[i];
      end
    end
    if (clrCarry) begin
      nextCcr[CCR_C] = 1'b0;
    end
    if (setCarry) begin
      nextCcr[CCR_C] = 1'b1;
    end
  end

  // Restore wins over a same-cycle save, which is then dropped without error
  assign popReq  = !stall && restoreFlags;
  assign pushReq = !stall && saveFlags && !restoreFlags;

  ccr_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (pushReq),
    .pop       (popReq),
    .pushData  (nextCcr),
    .topData_c (stackTop),
    .full_c    (stackFull),
    .empty_c   (stackEmpty),
    .count     (stackCount),
    .overflow  (stackOverflow),
    .underflow (stackUnderflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr <= '0;
    end else if (!stall) begin
      ccr <= (popReq && !stackEmpty) ? stackTop : nextCcr;
    end
  end

endmodule

// File: tb/tb_ccr_unit.sv
// Scoreboard bench for ccr_unit: a queue-based reference model predicts each
// cycle's branch decision and post-edge state; a monitor compares the DUT.
module tb_ccr_unit;
  import ccr_unit_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic       clk;
  logic       rst;
  logic       stall;
  logic [3:0] flagUpdateEn;
  logic       aluZero, aluNegative, aluCarry, aluOverflow;
  logic       setCarry, clrCarry;
  logic [2:0] branchType;
  logic       saveFlags, restoreFlags;
  logic [3:0] ccr;
  logic       branchTaken;
  logic       stackOverflow, stackUnderflow;
  logic [1:0] stackCount;

  ccr_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flagUpdateEn   (flagUpdateEn),
    .aluZero        (aluZero),
    .aluNegative    (aluNegative),
    .aluCarry       (aluCarry),
    .aluOverflow    (aluOverflow),
    .setCarry       (setCarry),
    .clrCarry       (clrCarry),
    .branchType     (branchType),
    .saveFlags      (saveFlags),
    .restoreFlags   (restoreFlags),
    .ccr            (ccr),
    .branchTaken    (branchTaken),
    .stackOverflow  (stackOverflow),
    .stackUnderflow (stackUnderflow),
    .stackCount     (stackCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       br;
    logic [3:0] ccr;
    logic [1:0] cnt;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  // Reference state: flags as a word, shadow stack as a queue
  logic [3:0] mCcr = 4'h0;
  logic [3:0] mStk[$];
  logic       mOvf = 1'b0;
  logic       mUnf = 1'b0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, predict its outcome, then advance past the edge
  task automatic apply(input logic r, input logic st, input logic [3:0] en,
                       input logic [3:0] alu, input logic sc, input logic cc,
                       input logic [2:0] bt, input logic sv, input logic rs);
    exp_t e;
    logic [3:0] nxt;
    rst = r; stall = st; flagUpdateEn = en;
    aluZero = alu[0]; aluNegative = alu[1]; aluCarry = alu[2]; aluOverflow = alu[3];
    setCarry = sc; clrCarry = cc; branchType = bt; saveFlags = sv; restoreFlags = rs;

    e.br = 1'b0;
    if (!st) begin
      case (bt)
        3'd1: e.br = mCcr[0];
        3'd2: e.br = mCcr[1];
        3'd3: e.br = mCcr[2];
        3'd4: e.br = 1'b1;
        default: e.br = 1'b0;
      endcase
    end

    if (r) begin
      mCcr = 4'h0;
      mStk.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
    end else if (!st) begin
      nxt = mCcr;
      if (e.br && bt >= 3'd1 && bt <= 3'd3) nxt[int'(bt) - 1] = 1'b0;
      for (int i = 0; i < 4; i++) if (en[i]) nxt[i] = alu[i];
      if (cc) nxt[2] = 1'b0;
      if (sc) nxt[2] = 1'b1;
      if (rs) begin
        if (mStk.size() > 0) nxt = mStk.pop_back();
        else mUnf = 1'b1;
      end else if (sv) begin
        if (mStk.size() < DEPTH) mStk.push_back(nxt);
        else mOvf = 1'b1;
      end
      mCcr = nxt;
    end

    e.ccr = mCcr;
    e.cnt = 2'(mStk.size());
    e.ovf = mOvf;
    e.unf = mUnf;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: branch decision mid-cycle, registered state just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("branchTaken", {3'b000, branchTaken}, {3'b000, e.br});
        @(posedge clk);
        #1;
        chk("ccr", ccr, e.ccr);
        chk("stackCount", {2'b00, stackCount}, {2'b00, e.cnt});
        chk("stackOverflow", {3'b000, stackOverflow}, {3'b000, e.ovf});
        chk("stackUnderflow", {3'b000, stackUnderflow}, {3'b000, e.unf});
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flagUpdateEn = '0;
    aluZero = 0; aluNegative = 0; aluCarry = 0; aluOverflow = 0;
    setCarry = 0; clrCarry = 0; branchType = '0; saveFlags = 0; restoreFlags = 0;
    @(posedge clk);
    #1;

    // Directed scenarios
    apply(1, 0, 4'h0, 4'h0,    0, 0, BR_NONE, 0, 0);
    apply(0, 0, 4'hF, 4'b0101, 0, 0, BR_NONE, 0, 0);
    apply(0, 0, 4'h1, 4'b0000, 0, 0, BR_NONE, 0, 0);
    apply(0, 0, 4'hF, 4'b0001, 0, 0, BR_NONE, 0, 0);
    apply(0, 0, 4'h0, 4'h0,    0, 0, BR_JZ,   0, 0);
    apply(0, 0, 4'h0, 4'h0,    0, 0, BR_JZ,   0, 0);
    apply(0, 0, 4'h0, 4'h0,    0, 0, BR_JMP,  0, 0);
    apply(0, 0, 4'h1, 4'b0001, 0, 0, BR_NONE, 0, 0);
    apply(0, 0, 4'h1, 4'b0001, 0, 0, BR_JZ,   0, 0);
    apply(0, 0, 4'h0, 4'h0,    1, 1, BR_NONE, 0, 0);
    apply(0, 0, 4'h0, 4'h0,    0, 0, BR_JC,   0, 0);
    apply(0, 0, 4'hF, 4'b0011, 0, 0, BR_NONE, 0, 0);
    apply(0, 0, 4'h0, 4'h0,    0, 0, BR_NONE, 1, 0);
    apply(0, 0, 4'hF, 4'b1100, 0, 0, BR_NONE, 1, 0);
    apply(0, 0, 4'h0, 4'h0,    0, 0, BR_NONE, 1, 0);
    apply(0, 0, 4'h0, 4'h0,    0, 0, BR_NONE, 0, 1);
    apply(0, 0, 4'h0, 4'h0,    0, 0, BR_NONE, 0, 1);
    apply(0, 0, 4'h0, 4'h0,    0, 0, BR_NONE, 0, 1);
    apply(0, 0, 4'hF, 4'b0001, 0, 0, BR_NONE, 1, 0);
    apply(0, 1, 4'hF, 4'b0000, 1, 0, BR_JZ,   1, 0);
    apply(0, 1, 4'h0, 4'h0,    0, 0, BR_NONE, 0, 1);
    apply(0, 0, 4'h0, 4'h0,    0, 0, BR_NONE, 1, 0);
    apply(0, 0, 4'h0, 4'h0,    0, 0, BR_NONE, 1, 0);
    apply(1, 0, 4'h0, 4'h0,    0, 0, BR_NONE, 0, 0);
    apply(0, 0, 4'hF, 4'b1010, 0, 0, BR_NONE, 1, 0);
    apply(0, 0, 4'hF, 4'b0110, 0, 0, BR_NONE, 1, 1);
    apply(0, 0, 4'h0, 4'h0,    0, 0, BR_JN,   0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 99) == 0,
            $urandom_range(0, 7) == 0,
            4'($urandom),
            4'($urandom),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
